sdram_cmd_arbiter: RTL and testbench
====================================

Name: sdram_cmd_arbiter

Overview:
Sits directly upstream of the SDRAM controller in the OV7670 frame-buffer path. Generates periodic auto-refresh requests and arbitrates them against burst-write requests (camera side) and burst-read requests (display side). Issues exactly one command at a time to the controller over a valid/ready/done handshake. Maintains wrapping frame word addresses for both streams.

Parameters:
ADDR_W, 24, width of SDRAM word address (bank+row+col).
BURST_LEN, 8, words per write/read burst; address step.
FRAME_WORDS, 307200, words per frame (640x480); address wraps here. Must be a multiple of BURST_LEN.
REF_PERIOD, 1040, sclk cycles between refresh requests (7.8 us at 133 MHz).

Ports:
sclk  in  1  system clock, 133 MHz
rst  in  1  synchronous, active-high reset
init_done  in  1  controller power-up init complete (level)
wr_req  in  1  write FIFO holds >= BURST_LEN words (level)
rd_req  in  1  read FIFO has room for >= BURST_LEN words (level)
wr_frame_start  in  1  pulse; reset write address to 0
rd_frame_start  in  1  pulse; reset read address to 0
cmd_valid  out  1  command offered to controller
cmd_type  out  2  01 refresh, 10 write, 11 read, 00 none
cmd_addr  out  ADDR_W  burst start address (0 for refresh)
cmd_ready  in  1  controller accepts command
cmd_done  in  1  pulse; accepted command finished
wr_ack  out  1  1-cycle pulse: write burst completed
rd_ack  out  1  1-cycle pulse: read burst completed
ref_miss  out  1  sticky: refresh period elapsed with refresh still pending

Behaviour:
- Reset: state WAIT_INIT; cmd_valid=0, cmd_type=00, cmd_addr=0, wr_ack=0, rd_ack=0, ref_miss=0; refresh counter=0, ref_pending=0; wr_addr=rd_addr=0; last_served=READ, so write wins the first tie. Reset mid-transaction abandons it immediately.
- Refresh timer: counts only when init_done=1. At count REF_PERIOD-1 it reloads 0 and sets ref_pending. If ref_pending is already set at that point, set ref_miss (sticky until rst). ref_pending clears in the cycle the refresh command handshakes (cmd_valid & cmd_ready).
- States:
  - WAIT_INIT -> IDLE when init_done=1.
  - IDLE: select a command, registered into cmd_type/cmd_addr. Priority: ref_pending > {wr_req, rd_req}. If both wr_req and rd_req are set, serve the opposite of last_served; otherwise serve whichever is set. Go to ISSUE if anything is selected, else stay in IDLE.
  - ISSUE: cmd_valid=1; type and addr held stable until cmd_ready=1. On handshake: cmd_valid drops the next cycle; update last_served for wr/rd; go to BUSY.
  - BUSY: wait for cmd_done -> IDLE. cmd_type stays at the issued value; cmd_valid=0.
- Latency: a request sampled in IDLE gives cmd_valid at the next edge. Minimum turnaround from cmd_done back to the next cmd_valid is 2 cycles.
- Completion: on cmd_done in BUSY:
  - write: wr_ack pulses; wr_addr <= (wr_addr+BURST_LEN == FRAME_WORDS) ? 0 : wr_addr+BURST_LEN.
  - read: rd_ack and rd_addr update likewise.
  - refresh: no ack.
- Frame start: wr_frame_start forces wr_addr=0. If it coincides with the write cmd_done, or arrives while a write is in ISSUE/BUSY, the pending increment is suppressed and the address ends at 0. An in-flight cmd_addr is not altered. rd_frame_start behaves symmetrically.
- cmd_ready outside ISSUE and cmd_done outside BUSY are ignored.
- A refresh becoming pending during ISSUE/BUSY of a wr/rd does not preempt; it is served at the next IDLE.
- Address arithmetic is unsigned, ADDR_W bits; FRAME_WORDS-BURST_LEN is the last legal burst address.

Test Plan:
- Reset, init_done=0 for 2000 cycles, wr_req=1 -> cmd_valid stays 0. After init_done=1: cmd_valid one cycle after IDLE, cmd_type=10, cmd_addr=0.
- wr_req=1 held, cmd_ready=1, cmd_done 10 cycles after each accept -> cmd_addr 0, 8, 16, …; wr_ack pulses once per burst.
- wr_req=rd_req=1 continuously, no refresh due -> types alternate 10, 11, 10, 11; wr_addr and rd_addr each advance by 8.
- Hold cmd_ready=0 for 3000 cycles -> ref_pending set at cycle 1040 of count after init_done; ref_miss=1 at the second period; cmd_type/cmd_addr stable throughout. Release -> refresh (01) served before any write.
- Preload wr_addr=307192, complete a write -> wr_addr wraps to 0. Next, pulse wr_frame_start in the same cycle as cmd_done at wr_addr=64 -> next write addr=0.
- Assert rst in BUSY -> next cycle cmd_valid=0, cmd_type=00, addresses 0, state WAIT_INIT; a later cmd_done causes no ack.

Source files
------------

// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter
//
// Arbiter sitting directly upstream of the SDRAM controller in the OV7670
// frame-buffer path. It generates periodic auto-refresh requests and
// arbitrates them against camera-side burst writes and display-side burst
// reads. Exactly one command at a time is offered to the controller over a
// valid/ready/done handshake. Wrapping frame word addresses are kept for both
// streams.
//
// Ports:
//   sclk            system clock (133 MHz)
//   rst             synchronous active-high reset
//   init_done       controller power-up init complete (level)
//   wr_req          write FIFO holds at least one burst (level)
//   rd_req          read FIFO has room for one burst (level)
//   wr_frame_start  pulse, restart the write stream at address 0
//   rd_frame_start  pulse, restart the read stream at address 0
//   cmd_valid       command offered to the controller
//   cmd_type        01 refresh, 10 write, 11 read, 00 none
//   cmd_addr        burst start address (0 for refresh)
//   cmd_ready       controller accepts the offered command
//   cmd_done        pulse, accepted command finished
//   wr_ack          1-cycle pulse, write burst completed
//   rd_ack          1-cycle pulse, read burst completed
//   ref_miss        sticky, a refresh period elapsed with a refresh pending
module sdram_cmd_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 307200,
  parameter int REF_PERIOD  = 1040
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              wr_frame_start,
  input  logic              rd_frame_start,
  output logic              cmd_valid,
  output logic [1:0]        cmd_type,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_ready,
  input  logic              cmd_done,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic              ref_miss
);

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    IDLE      = 2'd1,
    ISSUE     = 2'd2,
    BUSY      = 2'd3
  } state_t;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_REF  = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;
  localparam logic [1:0] CMD_RD   = 2'b11;

  localparam int                CNT_W      = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [CNT_W-1:0]  REF_LAST   = CNT_W'(REF_PERIOD - 1);
  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_WORDS);

  state_t            state_q;
  logic              cmdValid_q;
  logic [1:0]        cmdType_q;
  logic [ADDR_W-1:0] cmdAddr_q;
  logic              wrAck_q, rdAck_q;
  logic              lastRead_q;

  logic [CNT_W-1:0]  refCnt_q, refCnt_d;
  logic              refPending_q, refPending_d;
  logic              refMiss_q, refMiss_d;

  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
  logic              wrSupp_q, wrSupp_d;
  logic              rdSupp_q, rdSupp_d;

  logic              refTick, refHandshake;
  logic [1:0]        selType;
  logic [ADDR_W-1:0] selAddr;
  logic [ADDR_W-1:0] wrAddrInc, rdAddrInc;
  logic              wrDone, rdDone, wrInFlight, rdInFlight;

  assign cmd_valid = cmdValid_q;
  assign cmd_type  = cmdType_q;
  assign cmd_addr  = cmdAddr_q;
  assign wr_ack    = wrAck_q;
  assign rd_ack    = rdAck_q;
  assign ref_miss  = refMiss_q;

  // Command choice made while idle. Refresh always wins; a write/read tie
  // goes to whichever stream was not served last so neither can starve.
  always_comb begin
    selType = CMD_NONE;
    selAddr = '0;
    if (refPending_q) begin
      selType = CMD_REF;
    end else if (wr_req && rd_req) begin
      selType = lastRead_q ? CMD_WR : CMD_RD;
    end else if (wr_req) begin
      selType = CMD_WR;
    end else if (rd_req) begin
      selType = CMD_RD;
    end
    case (selType)
      CMD_WR:  selAddr = wrAddr_q;
      CMD_RD:  selAddr = rdAddr_q;
      default: selAddr = '0;
    endcase
  end

  assign refTick      = init_done && (refCnt_q == REF_LAST);
  assign refHandshake = (state_q == ISSUE) && cmd_ready && (cmdType_q == CMD_REF);

  // Refresh timer. A new period arriving while the previous refresh is still
  // pending (and not being accepted this very cycle) latches ref_miss.
  always_comb begin
    refCnt_d     = refCnt_q;
    refPending_d = refPending_q;
    refMiss_d    = refMiss_q;
    if (init_done) begin
      refCnt_d = refTick ? '0 : refCnt_q + CNT_W'(1);
    end
    if (refTick) begin
      refPending_d = 1'b1;
      if (refPending_q && !refHandshake) begin
        refMiss_d = 1'b1;
      end
    end else if (refHandshake) begin
      refPending_d = 1'b0;
    end
  end

  assign wrAddrInc = (wrAddr_q + BURST_STEP == FRAME_END) ? '0 : wrAddr_q + BURST_STEP;
  assign rdAddrInc = (rdAddr_q + BURST_STEP == FRAME_END) ? '0 : rdAddr_q + BURST_STEP;

  assign wrDone = (state_q == BUSY) && cmd_done && (cmdType_q == CMD_WR);
  assign rdDone = (state_q == BUSY) && cmd_done && (cmdType_q == CMD_RD);

  // A burst counts as in flight from the cycle it is selected until its done,
  // so a frame start anywhere in that window cancels the pending increment.
  assign wrInFlight = (((state_q == ISSUE) || (state_q == BUSY)) && (cmdType_q == CMD_WR)) ||
                      ((state_q == IDLE) && (selType == CMD_WR));
  assign rdInFlight = (((state_q == ISSUE) || (state_q == BUSY)) && (cmdType_q == CMD_RD)) ||
                      ((state_q == IDLE) && (selType == CMD_RD));

  // Stream address bookkeeping. The in-flight cmd_addr is never touched;
  // only the address used for the next burst is forced back to zero.
  always_comb begin
    wrAddr_d = wrAddr_q;
    wrSupp_d = wrSupp_q;
    if (wrDone) begin
      wrAddr_d = (wrSupp_q || wr_frame_start) ? '0 : wrAddrInc;
      wrSupp_d = 1'b0;
    end
    if (wr_frame_start) begin
      wrAddr_d = '0;
      if (wrInFlight && !wrDone) begin
        wrSupp_d = 1'b1;
      end
    end

    rdAddr_d = rdAddr_q;
    rdSupp_d = rdSupp_q;
    if (rdDone) begin
      rdAddr_d = (rdSupp_q || rd_frame_start) ? '0 : rdAddrInc;
      rdSupp_d = 1'b0;
    end
    if (rd_frame_start) begin
      rdAddr_d = '0;
      if (rdInFlight && !rdDone) begin
        rdSupp_d = 1'b1;
      end
    end
  end

  // Main controller FSM with registered command and ack outputs. Reset wins
  // over everything, abandoning any command in progress.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q      <= WAIT_INIT;
      cmdValid_q   <= 1'b0;
      cmdType_q    <= CMD_NONE;
      cmdAddr_q    <= '0;
      wrAck_q      <= 1'b0;
      rdAck_q      <= 1'b0;
      lastRead_q   <= 1'b1;
      refCnt_q     <= '0;
      refPending_q <= 1'b0;
      refMiss_q    <= 1'b0;
      wrAddr_q     <= '0;
      rdAddr_q     <= '0;
      wrSupp_q     <= 1'b0;
      rdSupp_q     <= 1'b0;
    end else begin
      refCnt_q     <= refCnt_d;
      refPending_q <= refPending_d;
      refMiss_q    <= refMiss_d;
      wrAddr_q     <= wrAddr_d;
      rdAddr_q     <= rdAddr_d;
      wrSupp_q     <= wrSupp_d;
      rdSupp_q     <= rdSupp_d;
      wrAck_q      <= 1'b0;
      rdAck_q      <= 1'b0;

      case (state_q)
        WAIT_INIT: begin
          if (init_done) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          cmdType_q <= selType;
          cmdAddr_q <= selAddr;
          if (selType != CMD_NONE) begin
            cmdValid_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmdValid_q <= 1'b0;
            state_q    <= BUSY;
            if (cmdType_q == CMD_WR) begin
              lastRead_q <= 1'b0;
            end else if (cmdType_q == CMD_RD) begin
              lastRead_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cmd_done) begin
            state_q <= IDLE;
            wrAck_q <= (cmdType_q == CMD_WR);
            rdAck_q <= (cmdType_q == CMD_RD);
          end
        end
        default: state_q <= WAIT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// tb_sdram_cmd_arbiter
//
// Self-checking bench for sdram_cmd_arbiter. The bench plays the SDRAM
// controller side of the handshake. A small frame size is used so that
// address wrap-around is reachable in a short run.
module tb_sdram_cmd_arbiter;

  localparam int ADDR_W      = 24;
  localparam int BURST_LEN   = 8;
  localparam int FRAME_WORDS = 128;
  localparam int REF_PERIOD  = 1040;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_REF  = 2'b01;
  localparam logic [1:0] T_WR   = 2'b10;
  localparam logic [1:0] T_RD   = 2'b11;

  logic              sclk = 1'b0;
  logic              rst, init_done, wr_req, rd_req;
  logic              wr_frame_start, rd_frame_start, cmd_ready, cmd_done;
  logic              cmd_valid;
  logic [1:0]        cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic              wr_ack, rd_ack, ref_miss;

  int total = 0;
  int bad   = 0;

  always #5 sclk = ~sclk;

  sdram_cmd_arbiter #(
    .ADDR_W      (ADDR_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .REF_PERIOD  (REF_PERIOD)
  ) dut (
    .sclk           (sclk),
    .rst            (rst),
    .init_done      (init_done),
    .wr_req         (wr_req),
    .rd_req         (rd_req),
    .wr_frame_start (wr_frame_start),
    .rd_frame_start (rd_frame_start),
    .cmd_valid      (cmd_valid),
    .cmd_type       (cmd_type),
    .cmd_addr       (cmd_addr),
    .cmd_ready      (cmd_ready),
    .cmd_done       (cmd_done),
    .wr_ack         (wr_ack),
    .rd_ack         (rd_ack),
    .ref_miss       (ref_miss)
  );

  // One directed vector: inputs packed as
  // {rst, init_done, wr_req, rd_req, wr_frame_start, rd_frame_start, cmd_ready, cmd_done}
  // and the outputs expected right after the edge that samples them.
  typedef struct {
    logic [7:0]        ins;
    logic              chkCmd;
    logic              expValid;
    logic [1:0]        expType;
    logic [ADDR_W-1:0] expAddr;
    logic              expWrAck;
    logic              expRdAck;
  } vec_t;

  vec_t vecs[$];

  // Reference model state for the random phase: a transaction view of the
  // arbiter (pending command, accepted or not) plus the refresh schedule.
  int         initEdges;
  logic       mStarted, mPending, mMiss, haveCmd, accepted, lastWasRead;
  logic       wrSupp, rdSupp, expWrAck, expRdAck;
  logic [1:0] curType;
  int         curAddr, mWrAddr, mRdAddr;

  function automatic vec_t mkVec(input logic [7:0] ins, input logic chkCmd, input logic expValid,
                                 input logic [1:0] expType, input int expAddr,
                                 input logic expWrAck, input logic expRdAck);
    vec_t v;
    v.ins      = ins;
    v.chkCmd   = chkCmd;
    v.expValid = expValid;
    v.expType  = expType;
    v.expAddr  = ADDR_W'(expAddr);
    v.expWrAck = expWrAck;
    v.expRdAck = expRdAck;
    return v;
  endfunction

  function automatic int nextAddr(input int a);
    return (a + BURST_LEN == FRAME_WORDS) ? 0 : a + BURST_LEN;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic clearInputs();
    init_done      = 1'b0;
    wr_req         = 1'b0;
    rd_req         = 1'b0;
    wr_frame_start = 1'b0;
    rd_frame_start = 1'b0;
    cmd_ready      = 1'b0;
    cmd_done       = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    {rst, init_done, wr_req, rd_req, wr_frame_start, rd_frame_start, cmd_ready, cmd_done} = v.ins;
    tick();
  endtask

  // Waits for an offered command, checks it, accepts it, finishes it after
  // doneDelay cycles and checks that the matching ack pulses exactly once.
  task automatic runBurst(input string name, input logic [1:0] expType, input int expAddr,
                          input int doneDelay, input logic frameAtDone);
    int n;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    checkOutput({name, " valid"}, 32'(cmd_valid), 32'(1));
    checkOutput({name, " type"}, 32'(cmd_type), 32'(expType));
    checkOutput({name, " addr"}, 32'(cmd_addr), 32'(expAddr));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checkOutput({name, " validDrop"}, 32'(cmd_valid), 32'(0));
    repeat (doneDelay - 1) tick();
    cmd_done = 1'b1;
    if (frameAtDone) wr_frame_start = 1'b1;
    tick();
    cmd_done       = 1'b0;
    wr_frame_start = 1'b0;
    checkOutput({name, " wrAck"}, 32'(wr_ack), 32'(expType == T_WR));
    checkOutput({name, " rdAck"}, 32'(rd_ack), 32'(expType == T_RD));
    tick();
    checkOutput({name, " ackPulse"}, 32'(wr_ack | rd_ack), 32'(0));
  endtask

  task automatic resetModel();
    initEdges   = 0;
    mStarted    = 1'b0;
    mPending    = 1'b0;
    mMiss       = 1'b0;
    haveCmd     = 1'b0;
    accepted    = 1'b0;
    lastWasRead = 1'b1;
    wrSupp      = 1'b0;
    rdSupp      = 1'b0;
    expWrAck    = 1'b0;
    expRdAck    = 1'b0;
    curType     = T_NONE;
    curAddr     = 0;
    mWrAddr     = 0;
    mRdAddr     = 0;
  endtask

  // Advances the model by one clock edge using the inputs the bench drove.
  task automatic modelEdge();
    logic       hs, doneHit, refTick, refClr;
    logic [1:0] sel;
    int         selAddr;
    expWrAck = 1'b0;
    expRdAck = 1'b0;
    hs       = haveCmd && !accepted && cmd_ready;
    doneHit  = haveCmd && accepted && cmd_done;
    refTick  = 1'b0;
    if (init_done) begin
      initEdges++;
      refTick = (initEdges % REF_PERIOD == 0);
    end

    sel     = T_NONE;
    selAddr = 0;
    if (!mStarted) begin
      mStarted = init_done;
    end else if (!haveCmd) begin
      if (mPending) sel = T_REF;
      else if (wr_req && rd_req) sel = lastWasRead ? T_WR : T_RD;
      else if (wr_req) sel = T_WR;
      else if (rd_req) sel = T_RD;
      if (sel == T_WR) selAddr = mWrAddr;
      if (sel == T_RD) selAddr = mRdAddr;
    end

    refClr = hs && (curType == T_REF);
    if (refTick) begin
      if (mPending && !refClr) mMiss = 1'b1;
      mPending = 1'b1;
    end else if (refClr) begin
      mPending = 1'b0;
    end

    if (hs) begin
      accepted = 1'b1;
      if (curType == T_WR) lastWasRead = 1'b0;
      if (curType == T_RD) lastWasRead = 1'b1;
    end

    if (wr_frame_start && !(doneHit && curType == T_WR) &&
        ((haveCmd && curType == T_WR) || sel == T_WR)) wrSupp = 1'b1;
    if (rd_frame_start && !(doneHit && curType == T_RD) &&
        ((haveCmd && curType == T_RD) || sel == T_RD)) rdSupp = 1'b1;

    if (doneHit) begin
      if (curType == T_WR) begin
        expWrAck = 1'b1;
        mWrAddr  = (wrSupp || wr_frame_start) ? 0 : nextAddr(mWrAddr);
        wrSupp   = 1'b0;
      end
      if (curType == T_RD) begin
        expRdAck = 1'b1;
        mRdAddr  = (rdSupp || rd_frame_start) ? 0 : nextAddr(mRdAddr);
        rdSupp   = 1'b0;
      end
      haveCmd  = 1'b0;
      accepted = 1'b0;
    end
    if (wr_frame_start) mWrAddr = 0;
    if (rd_frame_start) mRdAddr = 0;

    if (sel != T_NONE) begin
      haveCmd  = 1'b1;
      accepted = 1'b0;
      curType  = sel;
      curAddr  = selAddr;
    end
  endtask

  // Hard time limit so the run always ends even if the design wedges.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached, total=%0d", total);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    clearInputs();
    @(negedge sclk);

    // Directed vector table: reset, init, write, tie alternation, frame start.
    vecs.push_back(mkVec(8'b1000_0000, 1, 0, T_NONE, 0, 0, 0));
    vecs.push_back(mkVec(8'b0010_0000, 1, 0, T_NONE, 0, 0, 0));
    vecs.push_back(mkVec(8'b0010_0000, 1, 0, T_NONE, 0, 0, 0));
    vecs.push_back(mkVec(8'b0110_0000, 1, 0, T_NONE, 0, 0, 0));
    vecs.push_back(mkVec(8'b0110_0000, 1, 1, T_WR,   0, 0, 0));
    vecs.push_back(mkVec(8'b0110_0000, 1, 1, T_WR,   0, 0, 0));
    vecs.push_back(mkVec(8'b0110_0010, 1, 0, T_WR,   0, 0, 0));
    vecs.push_back(mkVec(8'b0111_0010, 1, 0, T_WR,   0, 0, 0));
    vecs.push_back(mkVec(8'b0111_0001, 0, 0, T_NONE, 0, 1, 0));
    vecs.push_back(mkVec(8'b0111_0000, 1, 1, T_RD,   0, 0, 0));
    vecs.push_back(mkVec(8'b0111_0010, 1, 0, T_RD,   0, 0, 0));
    vecs.push_back(mkVec(8'b0111_0001, 0, 0, T_NONE, 0, 0, 1));
    vecs.push_back(mkVec(8'b0111_0000, 1, 1, T_WR,   8, 0, 0));
    vecs.push_back(mkVec(8'b0111_0110, 1, 0, T_WR,   8, 0, 0));
    vecs.push_back(mkVec(8'b0111_0001, 0, 0, T_NONE, 0, 1, 0));
    vecs.push_back(mkVec(8'b0111_0000, 1, 1, T_RD,   0, 0, 0));
    vecs.push_back(mkVec(8'b0111_0010, 1, 0, T_RD,   0, 0, 0));
    vecs.push_back(mkVec(8'b0111_0001, 0, 0, T_NONE, 0, 0, 1));
    vecs.push_back(mkVec(8'b0100_0001, 0, 0, T_NONE, 0, 0, 0));
    vecs.push_back(mkVec(8'b0101_0000, 1, 1, T_RD,   8, 0, 0));
    vecs.push_back(mkVec(8'b0101_0010, 1, 0, T_RD,   8, 0, 0));
    vecs.push_back(mkVec(8'b0100_0001, 0, 0, T_NONE, 0, 0, 1));
    vecs.push_back(mkVec(8'b0110_0000, 1, 1, T_WR,  16, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d valid", i), 32'(cmd_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d wrAck", i), 32'(wr_ack), 32'(vecs[i].expWrAck));
      checkOutput($sformatf("vec%0d rdAck", i), 32'(rd_ack), 32'(vecs[i].expRdAck));
      checkOutput($sformatf("vec%0d refMiss", i), 32'(ref_miss), 32'(0));
      if (vecs[i].chkCmd) begin
        checkOutput($sformatf("vec%0d type", i), 32'(cmd_type), 32'(vecs[i].expType));
        checkOutput($sformatf("vec%0d addr", i), 32'(cmd_addr), 32'(vecs[i].expAddr));
      end
    end
    clearInputs();

    // Long wait for init: nothing may be issued before init_done.
    doReset();
    wr_req = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      tick();
      checkOutput("preInit valid", 32'(cmd_valid), 32'(0));
    end
    init_done = 1'b1;
    tick();
    checkOutput("initIdle valid", 32'(cmd_valid), 32'(0));
    tick();
    checkOutput("firstCmd valid", 32'(cmd_valid), 32'(1));
    checkOutput("firstCmd type", 32'(cmd_type), 32'(T_WR));
    checkOutput("firstCmd addr", 32'(cmd_addr), 32'(0));

    // Write stream with wrap-around, then a frame start coinciding with done.
    for (int i = 0; i < 24; i++) begin
      runBurst("wrStream", T_WR, (i * BURST_LEN) % FRAME_WORDS, 10, 1'b0);
    end
    runBurst("wrFrameAt64", T_WR, 64, 10, 1'b1);
    runBurst("wrAfterFrame", T_WR, 0, 10, 1'b0);

    // Controller stalls: refresh goes pending, then missed; command held stable.
    doReset();
    init_done = 1'b1;
    wr_req    = 1'b1;
    for (int k = 1; k <= 3000; k++) begin
      tick();
      if (k >= 2) begin
        checkOutput("stall valid", 32'(cmd_valid), 32'(1));
        checkOutput("stall type", 32'(cmd_type), 32'(T_WR));
        checkOutput("stall addr", 32'(cmd_addr), 32'(0));
      end
      checkOutput($sformatf("stall refMiss k=%0d", k), 32'(ref_miss), 32'(k >= 2 * REF_PERIOD));
    end
    runBurst("stallRelease", T_WR, 0, 3, 1'b0);
    runBurst("refreshFirst", T_REF, 0, 4, 1'b0);
    runBurst("wrAfterRef", T_WR, 8, 3, 1'b0);
    checkOutput("refMiss sticky", 32'(ref_miss), 32'(1));

    // Reset while a write is busy: everything clears and a late done is ignored.
    doReset();
    init_done = 1'b1;
    wr_req    = 1'b1;
    runBurst("preRst", T_WR, 0, 3, 1'b0);
    n = 0;
    while (cmd_valid !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    checkOutput("busyRst addr", 32'(cmd_addr), 32'(8));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tick();
    rst       = 1'b1;
    wr_req    = 1'b0;
    init_done = 1'b0;
    tick();
    rst = 1'b0;
    checkOutput("busyRst valid", 32'(cmd_valid), 32'(0));
    checkOutput("busyRst type", 32'(cmd_type), 32'(T_NONE));
    checkOutput("busyRst addr0", 32'(cmd_addr), 32'(0));
    checkOutput("busyRst refMiss", 32'(ref_miss), 32'(0));
    tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    checkOutput("lateDone wrAck", 32'(wr_ack), 32'(0));
    tick();
    checkOutput("lateDone wrAck2", 32'(wr_ack), 32'(0));
    init_done = 1'b1;
    wr_req    = 1'b1;
    runBurst("postRst", T_WR, 0, 3, 1'b0);

    // Random traffic against the reference model.
    doReset();
    resetModel();
    init_done = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      wr_req         = ($urandom_range(0, 9) < 6);
      rd_req         = ($urandom_range(0, 9) < 6);
      cmd_ready      = ($urandom_range(0, 1) == 1);
      cmd_done       = (haveCmd && accepted) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
      wr_frame_start = ($urandom_range(0, 49) == 0);
      rd_frame_start = ($urandom_range(0, 49) == 0);
      @(posedge sclk);
      modelEdge();
      @(negedge sclk);
      checkOutput($sformatf("rand%0d valid", c), 32'(cmd_valid), 32'(haveCmd && !accepted));
      if (haveCmd) begin
        checkOutput($sformatf("rand%0d type", c), 32'(cmd_type), 32'(curType));
        if (!accepted) begin
          checkOutput($sformatf("rand%0d addr", c), 32'(cmd_addr), 32'(curAddr));
        end
      end
      checkOutput($sformatf("rand%0d wrAck", c), 32'(wr_ack), 32'(expWrAck));
      checkOutput($sformatf("rand%0d rdAck", c), 32'(rd_ack), 32'(expRdAck));
      checkOutput($sformatf("rand%0d refMiss", c), 32'(ref_miss), 32'(mMiss));
    end
    clearInputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
